// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I operand-path hazard controller
// Tracks EX/MEM destinations, drives load-use stall, branch flush and registered forward selects.
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [6:0]       id_op,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             ex_br_taken,
   output logic             stall,
   output logic             flush_id,
   output logic [1:0]       ex_fwd_a,
   output logic [1:0]       ex_fwd_b,
   output logic             ex_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_IMM  = 7'b0010011;
   localparam logic [6:0] I_LOAD = 7'b0000011;
   localparam logic [6:0] S_TYPE = 7'b0100011;
   localparam logic [6:0] B_TYPE = 7'b1100011;

   typedef enum logic {RUN, STALL} state_t;

   state_t     state;

   logic       ex_v, ex_wr, ex_ld, ex_br;
   logic [4:0] ex_rd;
   logic       mem_v, mem_wr;
   logic [4:0] mem_rd;

   logic       use_rs1, use_rs2, wr_rd, is_ld, is_br;
   logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
   logic       load_use, advance;
   logic [1:0] fwd_a_nxt, fwd_b_nxt;

   always_comb begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      wr_rd   = 1'b0;
      is_ld   = 1'b0;
      is_br   = 1'b0;
      case (id_op)
         R_TYPE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
         I_IMM:  begin use_rs1 = 1'b1; wr_rd = 1'b1; end
         I_LOAD: begin use_rs1 = 1'b1; wr_rd = 1'b1; is_ld = 1'b1; end
         S_TYPE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
         B_TYPE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_br = 1'b1; end
         default: ;
      endcase
   end

   // x0 is hard-wired, so a zero source index never matches a producer
   always_comb begin
      ex_hit1  = use_rs1 && (id_rs1 != 5'd0) && ex_v && ex_wr && (ex_rd == id_rs1);
      ex_hit2  = use_rs2 && (id_rs2 != 5'd0) && ex_v && ex_wr && (ex_rd == id_rs2);
      mem_hit1 = use_rs1 && (id_rs1 != 5'd0) && mem_v && mem_wr && (mem_rd == id_rs1);
      mem_hit2 = use_rs2 && (id_rs2 != 5'd0) && mem_v && mem_wr && (mem_rd == id_rs2);
   end

   always_comb begin
      load_use = id_valid && ex_ld && (ex_hit1 || ex_hit2);
      flush_id = ex_br_taken && ex_v && ex_br;
      stall    = (state == RUN) && load_use && !flush_id;
      advance  = id_valid && !stall && !flush_id;
   end

   always_comb begin
      fwd_a_nxt = 2'b00;
      fwd_b_nxt = 2'b00;
      if (advance) begin
         if (ex_hit1)       fwd_a_nxt = 2'b01;
         else if (mem_hit1) fwd_a_nxt = 2'b10;
         if (ex_hit2)       fwd_b_nxt = 2'b01;
         else if (mem_hit2) fwd_b_nxt = 2'b10;
      end
   end

   assign ex_valid = ex_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         ex_v   <= 1'b0;
         ex_wr  <= 1'b0;
         ex_ld  <= 1'b0;
         ex_br  <= 1'b0;
         ex_rd  <= 5'd0;
         mem_v  <= 1'b0;
         mem_wr <= 1'b0;
         mem_rd <= 5'd0;
      end else begin
         case (state)
            RUN:     if (stall) state <= STALL;
            STALL:   state <= RUN;
            default: state <= RUN;
         endcase
         mem_v  <= ex_v;
         mem_wr <= ex_wr;
         mem_rd <= ex_rd;
         if (advance) begin
            ex_v  <= 1'b1;
            ex_wr <= wr_rd;
            ex_ld <= is_ld;
            ex_br <= is_br;
            ex_rd <= id_rd;
         end else begin
            ex_v  <= 1'b0;
            ex_wr <= 1'b0;
            ex_ld <= 1'b0;
            ex_br <= 1'b0;
            ex_rd <= 5'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_fwd_a  <= 2'b00;
         ex_fwd_b  <= 2'b00;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         ex_fwd_a <= fwd_a_nxt;
         ex_fwd_b <= fwd_b_nxt;
         if (stall)    stall_cnt <= stall_cnt + 1'b1;
         if (flush_id) flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

   localparam logic [6:0] R_TYPE = 7'b0110011;
   localparam logic [6:0] I_IMM  = 7'b0010011;
   localparam logic [6:0] I_LOAD = 7'b0000011;
   localparam logic [6:0] B_TYPE = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [6:0]  id_op;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        ex_br_taken;
   logic        stall, flush_id, ex_valid;
   logic [1:0]  ex_fwd_a, ex_fwd_b;
   logic [31:0] stall_cnt, flush_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
      .stall(stall), .flush_id(flush_id), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
      .ex_valid(ex_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
      id_valid = 1'b1;
      id_op    = op;
      id_rs1   = rs1;
      id_rs2   = rs2;
      id_rd    = rd;
      #1;
   endtask

   task automatic idle(input int n);
      id_valid = 1'b0;
      id_op    = 7'd0;
      id_rs1   = 5'd0;
      id_rs2   = 5'd0;
      id_rd    = 5'd0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_op = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
      id_rd = 5'd0; ex_br_taken = 1'b0;
      tick(); tick();
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_flush", {31'd0, flush_id}, 32'd0);
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 32'd0);
      check("rst_cnt", stall_cnt | flush_cnt, 32'd0);
      rst_n = 1'b1;
      tick();

      // add x5,x1,x2 ; add x6,x5,x3
      issue(R_TYPE, 5'd1, 5'd2, 5'd5);
      tick();
      issue(R_TYPE, 5'd5, 5'd3, 5'd6);
      check("t1_stall", {31'd0, stall}, 32'd0);
      tick();
      check("t1_valid", {31'd0, ex_valid}, 32'd1);
      check("t1_fwd_a", {30'd0, ex_fwd_a}, 32'd1);
      check("t1_fwd_b", {30'd0, ex_fwd_b}, 32'd0);
      idle(3);

      // add x5 ; addi x0 ; sub x7,x4,x5
      issue(R_TYPE, 5'd1, 5'd2, 5'd5);
      tick();
      issue(I_IMM, 5'd0, 5'd0, 5'd0);
      tick();
      issue(R_TYPE, 5'd4, 5'd5, 5'd7);
      tick();
      check("t2_fwd_a", {30'd0, ex_fwd_a}, 32'd0);
      check("t2_fwd_b", {30'd0, ex_fwd_b}, 32'd2);
      idle(3);

      // lw x8,0(x1) ; add x9,x8,x8
      issue(I_LOAD, 5'd1, 5'd0, 5'd8);
      tick();
      issue(R_TYPE, 5'd8, 5'd8, 5'd9);
      check("t3_stall_on", {31'd0, stall}, 32'd1);
      tick();
      check("t3_bubble", {31'd0, ex_valid}, 32'd0);
      check("t3_stall_off", {31'd0, stall}, 32'd0);
      tick();
      check("t3_valid", {31'd0, ex_valid}, 32'd1);
      check("t3_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 32'h0a);
      check("t3_stall_cnt", stall_cnt, 32'd1);
      idle(3);

      // lw x10 ; beq x1,x2 taken in EX while ID holds add x11,x10,x10
      issue(I_LOAD, 5'd1, 5'd0, 5'd10);
      tick();
      issue(B_TYPE, 5'd1, 5'd2, 5'd0);
      tick();
      issue(R_TYPE, 5'd10, 5'd10, 5'd11);
      ex_br_taken = 1'b1;
      #1;
      check("t4_flush", {31'd0, flush_id}, 32'd1);
      check("t4_stall", {31'd0, stall}, 32'd0);
      tick();
      ex_br_taken = 1'b0;
      check("t4_valid", {31'd0, ex_valid}, 32'd0);
      check("t4_flush_cnt", flush_cnt, 32'd1);
      check("t4_stall_cnt", stall_cnt, 32'd1);
      idle(3);

      // addi x0,x0,1 ; add x1,x0,x0
      issue(I_IMM, 5'd0, 5'd0, 5'd0);
      tick();
      issue(R_TYPE, 5'd0, 5'd0, 5'd1);
      tick();
      check("t5_valid", {31'd0, ex_valid}, 32'd1);
      check("t5_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 32'd0);
      idle(3);

      // reset while a load-use stall is pending
      issue(I_LOAD, 5'd1, 5'd0, 5'd8);
      tick();
      issue(R_TYPE, 5'd8, 5'd8, 5'd9);
      check("t6_pre_stall", {31'd0, stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_stall", {31'd0, stall}, 32'd0);
      check("t6_valid", {31'd0, ex_valid}, 32'd0);
      check("t6_cnt", stall_cnt | flush_cnt, 32'd0);
      tick();
      rst_n = 1'b1;
      idle(2);
      issue(R_TYPE, 5'd1, 5'd2, 5'd5);
      tick();
      issue(R_TYPE, 5'd5, 5'd3, 5'd6);
      check("t6_t1_stall", {31'd0, stall}, 32'd0);
      tick();
      check("t6_t1_fwd", {28'd0, ex_fwd_a, ex_fwd_b}, 32'h04);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
